// File: rtl/swap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : swap_pkg
// Description : Shared state encoding and requester ids for swap_sched.
// Revision    : 1.0 - initial release
// ============================================================================
package swap_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_B = 3'd3,
        ACK  = 3'd4
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/swap_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : swap_sched_if
// Description : Host port, swap requester handshakes and register file bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface swap_sched_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr_w;
    logic [ADDR_WIDTH-1:0] host_addr_r;
    logic [DATA_WIDTH-1:0] host_data_w;
    logic [DATA_WIDTH-1:0] host_data_r;
    logic                  host_stall;

    logic                  req0;
    logic                  req1;
    logic [ADDR_WIDTH-1:0] addr_a0;
    logic [ADDR_WIDTH-1:0] addr_b0;
    logic [ADDR_WIDTH-1:0] addr_a1;
    logic [ADDR_WIDTH-1:0] addr_b1;
    logic                  ack0;
    logic                  ack1;
    logic                  busy;

    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_addr_w;
    logic [ADDR_WIDTH-1:0] rf_addr_r;
    logic [DATA_WIDTH-1:0] rf_data_w;
    logic [DATA_WIDTH-1:0] rf_data_r;

    // Environment side: host, requesters and the register file model.
    modport master (
        output host_we, host_addr_w, host_addr_r, host_data_w,
        input  host_data_r, host_stall,
        output req0, req1, addr_a0, addr_b0, addr_a1, addr_b1,
        input  ack0, ack1, busy,
        input  rf_we, rf_addr_w, rf_addr_r, rf_data_w,
        output rf_data_r
    );

    // Controller side.
    modport slave (
        input  host_we, host_addr_w, host_addr_r, host_data_w,
        output host_data_r, host_stall,
        input  req0, req1, addr_a0, addr_b0, addr_a1, addr_b1,
        output ack0, ack1, busy,
        output rf_we, rf_addr_w, rf_addr_r, rf_data_w,
        input  rf_data_r
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way combinational round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
    input  wire logic [1:0] req,
    input  wire logic       last_grant,
    input  wire logic       en,
    output logic            gnt_valid,
    output logic            gnt_id
);

    always_comb begin
        gnt_valid = en && (req != 2'b00);
        // On contention the requester that did not win last time goes first.
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/swap_sched.sv
`default_nettype none
// ============================================================================
// Module      : swap_sched
// Description : Shares one register file between a host port and two swappers.
// Revision    : 1.0 - initial release
// ============================================================================
module swap_sched
    import swap_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic   clk,
    input  wire logic   reset,
    swap_sched_if.slave bus
);

    state_t                state;
    logic                  last_grant;
    logic                  gid;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] tmp;
    logic                  ack0_ff;
    logic                  ack1_ff;
    logic                  busy_ff;

    logic                  gnt_valid;
    logic                  gnt_id;
    logic [ADDR_WIDTH-1:0] sel_a;
    logic [ADDR_WIDTH-1:0] sel_b;

    logic                  mux_we;
    logic [ADDR_WIDTH-1:0] mux_addr_w;
    logic [ADDR_WIDTH-1:0] mux_addr_r;
    logic [DATA_WIDTH-1:0] mux_data_w;

    rr_arbiter_2 u_arb (
        .req        ({bus.req1, bus.req0}),
        .last_grant (last_grant),
        .en         (state == IDLE),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign sel_a = (gnt_id == REQ1) ? bus.addr_a1 : bus.addr_a0;
    assign sel_b = (gnt_id == REQ1) ? bus.addr_b1 : bus.addr_b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= REQ1;
            gid        <= REQ0;
            addr_a     <= '0;
            addr_b     <= '0;
            tmp        <= '0;
            ack0_ff    <= 1'b0;
            ack1_ff    <= 1'b0;
            busy_ff    <= 1'b0;
        end else begin
            ack0_ff <= 1'b0;
            ack1_ff <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        gid        <= gnt_id;
                        last_grant <= gnt_id;
                        addr_a     <= sel_a;
                        addr_b     <= sel_b;
                        busy_ff    <= 1'b1;
                        // Swapping a word with itself needs no register file traffic.
                        if (sel_a == sel_b) begin
                            state   <= ACK;
                            ack0_ff <= (gnt_id == REQ0);
                            ack1_ff <= (gnt_id == REQ1);
                        end else begin
                            state <= RD_A;
                        end
                    end
                end
                RD_A: begin
                    tmp   <= bus.rf_data_r;
                    state <= RD_B;
                end
                RD_B: begin
                    state <= WR_B;
                end
                WR_B: begin
                    state   <= ACK;
                    ack0_ff <= (gid == REQ0);
                    ack1_ff <= (gid == REQ1);
                end
                ACK: begin
                    state   <= IDLE;
                    busy_ff <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy_ff <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mux_we     = bus.host_we;
        mux_addr_w = bus.host_addr_w;
        mux_addr_r = bus.host_addr_r;
        mux_data_w = bus.host_data_w;
        case (state)
            IDLE: begin
            end
            RD_A: begin
                mux_we     = 1'b0;
                mux_addr_r = addr_a;
            end
            RD_B: begin
                // B's old value flows straight from the read port into A.
                mux_we     = 1'b1;
                mux_addr_r = addr_b;
                mux_addr_w = addr_a;
                mux_data_w = bus.rf_data_r;
            end
            WR_B: begin
                mux_we     = 1'b1;
                mux_addr_r = addr_b;
                mux_addr_w = addr_b;
                mux_data_w = tmp;
            end
            default: begin
                mux_we     = 1'b0;
                mux_addr_r = addr_b;
            end
        endcase
    end

    assign bus.rf_we       = mux_we;
    assign bus.rf_addr_w   = mux_addr_w;
    assign bus.rf_addr_r   = mux_addr_r;
    assign bus.rf_data_w   = mux_data_w;
    assign bus.host_data_r = bus.rf_data_r;
    assign bus.host_stall  = busy_ff;
    assign bus.busy        = busy_ff;
    assign bus.ack0        = ack0_ff;
    assign bus.ack1        = ack1_ff;

endmodule
`default_nettype wire

// File: tb/tb_swap_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_swap_sched
// Description : Directed self-checking bench for swap_sched with an RF model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_swap_sched;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [7:0] rf_mem [128];

    swap_sched_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();

    swap_sched #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_addr_w] <= bus.rf_data_w;
    end
    assign bus.rf_data_r = rf_mem[bus.rf_addr_r];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [6:0] a, input logic [7:0] d);
        bus.host_we     = 1'b1;
        bus.host_addr_w = a;
        bus.host_data_w = d;
        tick();
        bus.host_we     = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
        bus.host_addr_r = a;
        @(negedge clk);
        chk(tag, bus.host_data_r, exp);
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.host_we = 0; bus.host_addr_w = 0; bus.host_addr_r = 0; bus.host_data_w = 0;
        bus.req0 = 0; bus.req1 = 0;
        bus.addr_a0 = 0; bus.addr_b0 = 0; bus.addr_a1 = 0; bus.addr_b1 = 0;

        // Reset values
        @(negedge clk);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_stall", bus.host_stall, 0);
        chk("rst_ack0",  bus.ack0, 0);
        chk("rst_ack1",  bus.ack1, 0);
        tick();
        reset = 1'b1;

        host_write(7'd3, 8'h11);  host_write(7'd9, 8'h22);
        host_write(7'd1, 8'h01);  host_write(7'd2, 8'h02);
        host_write(7'd4, 8'h04);  host_write(7'd5, 8'h05);
        host_write(7'd7, 8'h5C);  host_write(7'd10, 8'h0A);

        // Host pass-through
        bus.host_we = 1; bus.host_addr_w = 7'd5; bus.host_data_w = 8'hAA;
        @(negedge clk);
        chk("pt_we",    bus.rf_we, 1);
        chk("pt_addrw", bus.rf_addr_w, 5);
        tick();
        bus.host_we = 0;
        rd_chk("pt_rd5", 7'd5, 8'hAA);
        chk("pt_stall", bus.host_stall, 0);
        chk("pt_ack0",  bus.ack0, 0);
        chk("pt_ack1",  bus.ack1, 0);
        host_write(7'd5, 8'h05);

        // Single swap 3 <-> 9
        bus.addr_a0 = 7'd3; bus.addr_b0 = 7'd9; bus.req0 = 1;
        @(negedge clk);
        chk("s_g_stall", bus.host_stall, 0);
        tick(); @(negedge clk);
        chk("s1_busy", bus.busy, 1);
        chk("s1_we",   bus.rf_we, 0);
        chk("s1_ar",   bus.rf_addr_r, 3);
        tick(); @(negedge clk);
        chk("s2_we",   bus.rf_we, 1);
        chk("s2_aw",   bus.rf_addr_w, 3);
        chk("s2_dw",   bus.rf_data_w, 8'h22);
        chk("s2_ack0", bus.ack0, 0);
        tick(); @(negedge clk);
        chk("s3_we",   bus.rf_we, 1);
        chk("s3_aw",   bus.rf_addr_w, 9);
        chk("s3_dw",   bus.rf_data_w, 8'h11);
        chk("s3_ack0", bus.ack0, 0);
        tick(); @(negedge clk);
        chk("s4_ack0", bus.ack0, 1);
        chk("s4_ack1", bus.ack1, 0);
        chk("s4_we",   bus.rf_we, 0);
        tick();
        bus.req0 = 0;
        @(negedge clk);
        chk("s5_ack0", bus.ack0, 0);
        chk("s5_busy", bus.busy, 0);
        tick();
        rd_chk("s_rd3", 7'd3, 8'h22);
        rd_chk("s_rd9", 7'd9, 8'h11);

        // Round robin after reset; req0 is re-asserted to contend again
        reset = 0; tick(); reset = 1;
        bus.addr_a0 = 7'd1; bus.addr_b0 = 7'd2;
        bus.addr_a1 = 7'd4; bus.addr_b1 = 7'd5;
        bus.req0 = 1; bus.req1 = 1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 10) bus.req1 = 0;
            if (i == 15) bus.req0 = 0;
            @(negedge clk);
            chk($sformatf("rr_ack0_%0d", i), bus.ack0, (i == 4 || i == 14) ? 1 : 0);
            chk($sformatf("rr_ack1_%0d", i), bus.ack1, (i == 9) ? 1 : 0);
        end
        tick();
        rd_chk("rr_rd1", 7'd1, 8'h01);
        rd_chk("rr_rd2", 7'd2, 8'h02);
        rd_chk("rr_rd4", 7'd4, 8'h05);
        rd_chk("rr_rd5", 7'd5, 8'h04);

        // Same-address swap
        bus.addr_a1 = 7'd7; bus.addr_b1 = 7'd7; bus.req1 = 1;
        tick(); @(negedge clk);
        chk("sa_ack1", bus.ack1, 1);
        chk("sa_we",   bus.rf_we, 0);
        chk("sa_busy", bus.busy, 1);
        tick();
        bus.req1 = 0;
        @(negedge clk);
        chk("sa_ack1_off", bus.ack1, 0);
        chk("sa_busy_off", bus.busy, 0);
        chk("sa_we2",      bus.rf_we, 0);
        tick();
        rd_chk("sa_rd7", 7'd7, 8'h5C);

        // Host write during RD_B is ignored
        bus.addr_a0 = 7'd3; bus.addr_b0 = 7'd9; bus.req0 = 1;
        tick();
        tick();
        bus.host_we = 1; bus.host_addr_w = 7'd10; bus.host_data_w = 8'hFF;
        @(negedge clk);
        chk("hs_stall", bus.host_stall, 1);
        chk("hs_aw",    bus.rf_addr_w, 3);
        tick();
        bus.host_we = 0;
        tick();
        tick();
        bus.req0 = 0;
        tick();
        rd_chk("hs_rd10", 7'd10, 8'h0A);
        rd_chk("hs_rd3",  7'd3,  8'h11);
        rd_chk("hs_rd9",  7'd9,  8'h22);

        // Host write in the grant cycle lands before RD_A
        bus.host_we = 1; bus.host_addr_w = 7'd3; bus.host_data_w = 8'hFF;
        bus.req0 = 1;
        tick();
        bus.host_we = 0;
        tick(); tick(); tick(); tick();
        bus.req0 = 0;
        tick();
        rd_chk("gw_rd9", 7'd9, 8'hFF);
        rd_chk("gw_rd3", 7'd3, 8'h22);

        // Reset during WR_B
        host_write(7'd9, 8'h33);
        bus.req0 = 1;
        tick(); tick(); tick();
        reset = 0;
        @(negedge clk);
        chk("mr_busy",  bus.busy, 0);
        chk("mr_stall", bus.host_stall, 0);
        chk("mr_ack0",  bus.ack0, 0);
        chk("mr_we",    bus.rf_we, 0);
        bus.req0 = 0;
        tick();
        reset = 1;
        @(negedge clk);
        chk("mr_ack0_b", bus.ack0, 0);
        chk("mr_busy_b", bus.busy, 0);
        tick();
        rd_chk("mr_rd3", 7'd3, 8'h33);
        rd_chk("mr_rd9", 7'd9, 8'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/swap_sched.md
Name: swap_sched

Overview:
- Controller that shares one single-port-read, single-port-write register file between a host access port and two independent swap requesters.
- Arbitrates the two swap requesters round-robin.
- Sequences each granted swap as a read-A / read-B+write-A / write-B micro-sequence with a temporary holding register.
- The host port passes straight through while idle and is stalled while a swap is in flight.
- Sits between the requesting datapaths and the register file instance; the register file itself sits outside this block.

Parameters:
- ADDR_WIDTH, 7, register file address width (2^ADDR_WIDTH entries).
- DATA_WIDTH, 8, register file word width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- host_we  in  1  host write enable.
- host_addr_w  in  ADDR_WIDTH  host write address.
- host_addr_r  in  ADDR_WIDTH  host read address.
- host_data_w  in  DATA_WIDTH  host write data.
- host_data_r  out  DATA_WIDTH  host read data (= rf_data_r).
- host_stall  out  1  1 = host access ignored this cycle.
- req0, req1  in  1 each  swap request, level, held until matching ack.
- addr_a0, addr_b0, addr_a1, addr_b1  in  ADDR_WIDTH each  swap operands; stable while the matching req is high.
- ack0, ack1  out  1 each  one-cycle done pulse to the matching requester.
- busy  out  1  swap sequence in progress (state != IDLE).
- rf_we  out  1  register file write enable.
- rf_addr_w  out  ADDR_WIDTH  register file write address.
- rf_addr_r  out  ADDR_WIDTH  register file read address.
- rf_data_w  out  DATA_WIDTH  register file write data.
- rf_data_r  in  DATA_WIDTH  register file combinational read data.

Behaviour:
- Reset (reset=0, async): state=IDLE, last_grant=1 (requester 0 wins first), tmp=0, latched addr_a/addr_b/gid=0. Outputs: ack0=ack1=0, busy=0, host_stall=0.
- rf_* are combinational decodes of state. In IDLE they mirror the host port: rf_we=host_we, rf_addr_w=host_addr_w, rf_addr_r=host_addr_r, rf_data_w=host_data_w.
- IDLE: the host access executes this cycle. If any req is high, grant it at the rising edge:
  - only one req high: grant that requester.
  - both high: grant the requester != last_grant.
  - at the grant edge, latch addr_a/addr_b and gid from the granted requester, and set last_grant=gid.
  - next state: ACK if addr_a==addr_b, else RD_A.
- RD_A: rf_addr_r=addr_a, rf_we=0, tmp<=rf_data_r. Next state RD_B.
- RD_B: rf_addr_r=addr_b, rf_we=1, rf_addr_w=addr_a, rf_data_w=rf_data_r (B's old value written into A). Next state WR_B.
- WR_B: rf_we=1, rf_addr_w=addr_b, rf_data_w=tmp. Next state ACK.
- ACK: rf_we=0. ack[gid]=1 for exactly this cycle. Next state IDLE.
  - The requester must drop req at the edge ending the ack cycle.
  - A req still high in the following IDLE cycle is treated as a new swap.
- Latency: grant edge at end of cycle g gives RD_A g+1, RD_B g+2, WR_B g+3, ack at g+4. Same-address swap: ack at g+1, no writes.
- Throughput: one swap per 5 cycles, including one idle host cycle between consecutive swaps (the host is guaranteed at least 1 cycle in 5).
- host_stall=busy. In non-IDLE states host inputs are ignored (no write); host_data_r still shows rf_data_r for the swap address.
- A host write in the grant cycle to addr_a or addr_b lands before RD_A, so the swap uses the new value.
- Requests arriving while busy stay pending; addresses are not sampled until their grant.
- Reset mid-sequence: immediate return to IDLE. A partially completed swap is not rolled back (A may already hold B's value), and no ack is issued.
- No ack is ever generated for a requester whose req was low at the grant edge.

Decomposition:
- Shared package (swap_pkg):
  - state encoding: IDLE=3'd0, RD_A=3'd1, RD_B=3'd2, WR_B=3'd3, ACK=3'd4.
  - requester id constants REQ0=1'b0, REQ1=1'b1.
- Sub-module rr_arbiter_2:
  - inputs: req[1:0], last_grant, en.
  - outputs: gnt_valid, gnt_id.
  - purely combinational.
- The FSM, latches and rf mux stay in swap_sched.

Test Plan:
- Reset and host pass-through: preload rf[3]=8'h11; host write rf[5]=8'hAA, then read addr 5 -> host_data_r=8'hAA, host_stall=0, ack0=ack1=0.
- Single swap: rf[3]=8'h11, rf[9]=8'h22; req0 with a=3, b=9 -> rf_we pulses at g+2 (addr 3, data 8'h22) and g+3 (addr 9, data 8'h11); ack0 high only at g+4; afterwards rf[3]=8'h22, rf[9]=8'h11.
- Simultaneous requests after reset: req0 (1,2) and req1 (4,5) both high -> requester 0 served first (ack0 at g+4), requester 1 next (ack1 at g+9); on the next simultaneous pair requester 1 wins.
- Same-address swap: req1 with a=b=7, rf[7]=8'h5C -> ack1 one cycle after grant, no rf_we pulses, rf[7] unchanged.
- Host stall: host_we=1 to addr 10 with data 8'hFF during RD_B -> host_stall=1 and rf[10] unchanged. The same write in the IDLE grant cycle to addr_a=3 -> swap moves 8'hFF into rf[9].
- Reset mid-swap: drive reset=0 during WR_B -> state IDLE, busy=0, no ack; rf[3] already holds B's value and rf[9] keeps its old value.
